// File: rtl/mul_byte_sequencer.sv
// Byte-serial front/back end for a 16x16 combinational multiplier: gathers two
// 16-bit operands from an 8-bit bus, waits MUL_LATENCY cycles, returns the product as 4 bytes.
module mul_byte_sequencer #(
  parameter int unsigned MUL_LATENCY = 1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [7:0]  IN_DATA,
  input  logic        IN_VALID,
  output logic        IN_READY,
  output logic [7:0]  OUT_DATA,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic        OUT_LAST,
  output logic [15:0] MUL_A,
  output logic [15:0] MUL_B,
  input  logic [31:0] MUL_RESULT,
  output logic        BUSY,
  output logic [1:0]  DBG_STATE
);

  // Handshake: a byte moves on a rising edge where VALID and READY are both 1;
  // READY/VALID are registered and never depend combinationally on the other side.

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_WAIT = 2'd1,
    S_SEND = 2'd2
  } state_t;

  localparam logic [3:0] LAT = 4'(MUL_LATENCY);

  state_t      state;
  state_t      state_next;
  logic [1:0]  idx;
  logic [1:0]  nxt;
  logic [3:0]  cnt;
  logic [31:0] result;
  logic [31:0] shifted;
  logic        in_ready_q;
  logic        out_valid_q;
  logic        out_last_q;
  logic [7:0]  out_data_q;
  logic [15:0] mul_a_q;
  logic [15:0] mul_b_q;
  logic        in_fire;
  logic        out_fire;

  assign in_fire  = IN_VALID && in_ready_q;
  assign out_fire = out_valid_q && OUT_READY;
  assign nxt      = idx + 2'd1;
  assign shifted  = result >> {nxt, 3'b000};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= S_LOAD;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_LOAD: if (in_fire && idx == 2'd3) state_next = S_WAIT;
      S_WAIT: if (cnt <= 4'd1) state_next = S_SEND;
      S_SEND: if (out_fire && idx == 2'd3) state_next = S_LOAD;
      default: state_next = S_LOAD;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      idx         <= 2'd0;
      cnt         <= 4'd0;
      result      <= 32'd0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= 8'd0;
      mul_a_q     <= 16'd0;
      mul_b_q     <= 16'd0;
    end else begin
      case (state)
        S_LOAD: begin
          in_ready_q <= 1'b1;
          if (in_fire) begin
            case (idx)
              2'd0: mul_a_q[7:0]  <= IN_DATA;
              2'd1: mul_a_q[15:8] <= IN_DATA;
              2'd2: mul_b_q[7:0]  <= IN_DATA;
              default: mul_b_q[15:8] <= IN_DATA;
            endcase
            idx <= nxt;
            if (idx == 2'd3) begin
              cnt        <= LAT;
              in_ready_q <= 1'b0;
            end
          end
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          // Capture edge: the multicycle product path has settled by now.
          if (cnt <= 4'd1) begin
            result      <= MUL_RESULT;
            out_data_q  <= MUL_RESULT[7:0];
            out_valid_q <= 1'b1;
            out_last_q  <= 1'b0;
            idx         <= 2'd0;
          end
        end
        S_SEND: begin
          if (out_fire) begin
            idx <= nxt;
            if (idx == 2'd3) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              in_ready_q  <= 1'b1;
            end else begin
              out_data_q <= shifted[7:0];
              out_last_q <= (nxt == 2'd3);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign IN_READY  = in_ready_q;
  assign OUT_VALID = out_valid_q;
  assign OUT_LAST  = out_last_q;
  assign OUT_DATA  = out_data_q;
  assign MUL_A     = mul_a_q;
  assign MUL_B     = mul_b_q;
  assign BUSY      = (state != S_LOAD);
  assign DBG_STATE = state;

endmodule
